// File: rtl/mult_share_ctrl.sv
// Round-robin sequencer sharing one 4x4 multiplier between two requesters.
// Ports: clock_100Mhz, reset (async low), req/X/Y x2 in; gnt/done x2, Z, busy out.
module mult_share_ctrl #(
  parameter int unsigned MUL_CYCLES = 1
) (
  input  logic       clock_100Mhz,
  input  logic       reset,
  input  logic       req0,
  input  logic [3:0] X0,
  input  logic [3:0] Y0,
  input  logic       req1,
  input  logic [3:0] X1,
  input  logic [3:0] Y1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] Z,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_e;

  localparam logic [3:0] CNT_LOAD = 4'(MUL_CYCLES - 1);

  state_e     state_q, state_d;
  logic       ptr_q, ptr_d;
  logic       own_q, own_d;
  logic [3:0] xa_q, xa_d;
  logic [3:0] ya_q, ya_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] z_q, z_d;
  logic       gnt0_q, gnt0_d;
  logic       gnt1_q, gnt1_d;
  logic       done0_q, done0_d;
  logic       done1_q, done1_d;
  logic       busy_q, busy_d;
  logic       win;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    xa_d    = xa_q;
    ya_d    = ya_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    win     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          // Contention is settled by the pointer.
          if (req0 && req1) begin
            win = ptr_q;
          end else begin
            win = req1;
          end
          own_d   = win;
          xa_d    = win ? X1 : X0;
          ya_d    = win ? Y1 : Y0;
          cnt_d   = CNT_LOAD;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          z_d     = 8'(xa_q) * 8'(ya_q);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        ptr_d   = ~own_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next-state view so they
  // line up with the state they describe.
  always_comb begin
    busy_d  = (state_d != S_IDLE);
    gnt0_d  = busy_d && !own_d;
    gnt1_d  = busy_d && own_d;
    done0_d = (state_d == S_DONE) && !own_d;
    done1_d = (state_d == S_DONE) && own_d;
  end

  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b0;
      own_q   <= 1'b0;
      xa_q    <= 4'd0;
      ya_q    <= 4'd0;
      cnt_q   <= 4'd0;
      z_q     <= 8'h00;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      xa_q    <= xa_d;
      ya_q    <= ya_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt0  = gnt0_q;
  assign gnt1  = gnt1_q;
  assign done0 = done0_q;
  assign done1 = done1_q;
  assign Z     = z_q;
  assign busy  = busy_q;

endmodule
